// File: rtl/data_sram_bridge.sv
// Bridges the CPU's single-cycle data SRAM port onto a split-transaction
// bus with addr_ok/data_ok handshakes, stalling the pipeline until done.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   data_sram_en/wen/addr/    CPU request from EX (wen 0000 = read)
//     wdata
//   data_sram_rdata           registered load data, held for MEM
//   stallreq                  stall request to pipeline control
//   bus_req/wr/wstrb/addr/    bus request, held stable while pending
//     wdata
//   bus_addr_ok/data_ok/      slave accept, response and read data
//     rdata
//   err                       sticky timeout flag
module data_sram_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_bus_req;
  logic          r_bus_wr;
  logic [3:0]    r_bus_wstrb;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic w_launch;
  logic w_done_ok;
  logic w_timeout;
  logic w_age_hit;
  logic w_busy;

  assign w_age_hit = (r_cnt == LAST);
  assign w_busy    = (r_state == S_REQ) ||
                     (r_state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A response only counts in REQ when the
  // request is accepted in the same cycle;
  // a real completion beats the timeout.
  always_comb begin
    w_next    = r_state;
    w_launch  = 1'b0;
    w_done_ok = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (data_sram_en) begin
          w_launch = 1'b1;
          w_next   = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_addr_ok && bus_data_ok) begin
          w_done_ok = 1'b1;
          w_next    = S_DONE;
        end else if (w_age_hit) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end else if (bus_addr_ok) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus_data_ok) begin
          w_done_ok = 1'b1;
          w_next    = S_DONE;
        end else if (w_age_hit) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_wstrb <= 4'h0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
    end else begin
      if (w_launch) begin
        r_cnt       <= '0;
        r_bus_req   <= 1'b1;
        r_bus_wr    <= |data_sram_wen;
        r_bus_wstrb <= data_sram_wen;
        r_bus_addr  <= data_sram_addr;
        r_bus_wdata <= data_sram_wdata;
      end else if (w_busy && !w_age_hit) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_REQ &&
          (bus_addr_ok || w_timeout)) begin
        r_bus_req <= 1'b0;
      end
    end
  end

  // Load data only moves on a read completion,
  // so MEM sees a stable value across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_done_ok && !r_bus_wr) begin
        r_rdata <= bus_rdata;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
        if (!r_bus_wr) begin
          r_rdata <= ERR_DATA;
        end
      end
    end
  end

  assign stallreq = !rst &&
    ((r_state == S_IDLE && data_sram_en) ||
     w_busy);

  assign data_sram_rdata = r_rdata;
  assign bus_req         = r_bus_req;
  assign bus_wr          = r_bus_wr;
  assign bus_wstrb       = r_bus_wstrb;
  assign bus_addr        = r_bus_addr;
  assign bus_wdata       = r_bus_wdata;
  assign err             = r_err;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge with a transaction-level
// reference model checked on every falling edge.
module tb_data_sram_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        breq;
  logic        bwr;
  logic [3:0]  bstrb;
  logic [31:0] baddr;
  logic [31:0] bwdata;
  logic        aok;
  logic        dok;
  logic [31:0] brdata;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;
  int n_acc = 0;
  int acc_base;

  data_sram_bridge #(
    .TIMEOUT_CYC(TO),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_sram_en(en),
    .data_sram_wen(wen),
    .data_sram_addr(addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .stallreq(stall),
    .bus_req(breq),
    .bus_wr(bwr),
    .bus_wstrb(bstrb),
    .bus_addr(baddr),
    .bus_wdata(bwdata),
    .bus_addr_ok(aok),
    .bus_data_ok(dok),
    .bus_rdata(brdata),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding request,
  // its age, whether the slave took it, and a
  // one-cycle "just finished" tail.
  bit          m_valid = 0;
  bit          m_busy = 0;
  bit          m_acc = 0;
  bit          m_tail = 0;
  int          m_age = 0;
  bit          m_wr = 0;
  logic [3:0]  m_strb = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] m_rdata = 0;
  bit          m_err = 0;

  always @(posedge clk) begin
    bit fin;
    if (rst) begin
      m_valid = 1;
      m_busy = 0; m_acc = 0; m_tail = 0;
      m_age = 0; m_wr = 0; m_strb = 0;
      m_addr = 0; m_wdata = 0;
      m_rdata = 0; m_err = 0;
    end else if (m_tail) begin
      m_tail = 0;
    end else if (!m_busy) begin
      if (en) begin
        m_busy = 1; m_acc = 0; m_age = 0;
        m_wr = (wen != 0); m_strb = wen;
        m_addr = addr; m_wdata = wdata;
      end
    end else begin
      fin = m_acc ? dok : (aok && dok);
      if (aok) m_acc = 1;
      m_age++;
      if (fin) begin
        if (!m_wr) m_rdata = brdata;
        m_busy = 0; m_tail = 1;
      end else if (m_age == TO) begin
        m_err = 1;
        if (!m_wr) m_rdata = 32'hDEAD_BEEF;
        m_busy = 0; m_tail = 1;
      end
    end
  end

  always @(posedge clk)
    if (!rst && breq && aok) n_acc++;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_stall", {31'd0, stall},
          {31'd0, !rst && (m_busy ||
            (!m_tail && en))});
      chk("m_req", {31'd0, breq},
          {31'd0, m_busy && !m_acc});
      chk("m_wr", {31'd0, bwr}, {31'd0, m_wr});
      chk("m_strb", {28'd0, bstrb}, {28'd0, m_strb});
      chk("m_addr", baddr, m_addr);
      chk("m_wdata", bwdata, m_wdata);
      chk("m_rdata", rdata, m_rdata);
      chk("m_err", {31'd0, err}, {31'd0, m_err});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit e, input logic [3:0] w,
                     input logic [31:0] a,
                     input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
  endtask

  task automatic slv(input bit a, input bit d,
                     input logic [31:0] r);
    aok = a; dok = d; brdata = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    drv(0, 4'h0, 32'h0, 32'h0);
    slv(0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, breq}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'd0, err}, 32'd0);
    cyc();
    rst = 0;

    // read, zero-wait slave
    drv(1, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    chk("r0_stall1", {31'd0, stall}, 32'd1);
    cyc();
    slv(1, 1, 32'h1234_5678);
    @(negedge clk);
    chk("r0_stall2", {31'd0, stall}, 32'd1);
    chk("r0_addr", baddr, 32'h100);
    cyc();
    slv(0, 0, 32'h0);
    @(negedge clk);
    chk("r0_done_stall", {31'd0, stall}, 32'd0);
    chk("r0_rdata", rdata, 32'h1234_5678);
    cyc();
    drv(0, 4'h0, 32'h0, 32'h0);

    // read, addr_ok after 1, data_ok 3 later
    cyc();
    drv(1, 4'h0, 32'h108, 32'h0);
    cyc(2);
    slv(1, 0, 32'h0);
    @(negedge clk);
    chk("r3_req", {31'd0, breq}, 32'd1);
    cyc();
    slv(0, 0, 32'h0);
    @(negedge clk);
    chk("r3_req_drop", {31'd0, breq}, 32'd0);
    chk("r3_stall", {31'd0, stall}, 32'd1);
    cyc(2);
    slv(0, 1, 32'hCAFE_F00D);
    @(negedge clk);
    chk("r3_hold", rdata, 32'h1234_5678);
    cyc();
    slv(0, 0, 32'h0);
    @(negedge clk);
    chk("r3_rdata", rdata, 32'hCAFE_F00D);
    cyc();
    drv(0, 4'h0, 32'h0, 32'h0);

    // halfword write
    cyc();
    drv(1, 4'b0011, 32'h204, 32'hAABB_CCDD);
    cyc();
    slv(1, 0, 32'h0);
    @(negedge clk);
    chk("w_wr", {31'd0, bwr}, 32'd1);
    chk("w_strb", {28'd0, bstrb}, 32'h3);
    chk("w_addr", baddr, 32'h204);
    chk("w_wdata", bwdata, 32'hAABB_CCDD);
    cyc();
    slv(0, 1, 32'h5555_5555);
    cyc();
    slv(0, 0, 32'h0);
    @(negedge clk);
    chk("w_rdata_kept", rdata, 32'hCAFE_F00D);
    cyc();
    drv(0, 4'h0, 32'h0, 32'h0);

    // back-to-back read then store, en held
    cyc();
    acc_base = n_acc;
    drv(1, 4'h0, 32'h300, 32'h0);
    cyc();
    slv(1, 1, 32'h1111_2222);
    cyc();
    slv(0, 0, 32'h0);
    cyc();
    drv(1, 4'hF, 32'h304, 32'h5566_7788);
    cyc();
    slv(1, 1, 32'h0);
    cyc();
    slv(0, 0, 32'h0);
    cyc();
    drv(0, 4'h0, 32'h0, 32'h0);
    cyc(2);
    chk("b2b_count", n_acc - acc_base, 32'd2);
    chk("b2b_rdata", rdata, 32'h1111_2222);

    // stray handshakes while idle
    slv(1, 1, 32'h0BAD_F00D);
    cyc();
    slv(0, 0, 32'h0);
    @(negedge clk);
    chk("stray_rdata", rdata, 32'h1111_2222);

    // timeout: slave accepts, never answers
    cyc();
    drv(1, 4'h0, 32'h400, 32'h0);
    cyc();
    slv(1, 0, 32'h0);
    cyc();
    slv(0, 0, 32'h0);
    cyc(6);
    @(negedge clk);
    chk("to_pre_err", {31'd0, err}, 32'd0);
    chk("to_pre_stall", {31'd0, stall}, 32'd1);
    cyc();
    @(negedge clk);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rdata", rdata, 32'hDEAD_BEEF);
    chk("to_stall", {31'd0, stall}, 32'd0);
    cyc();
    drv(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("to_sticky", {31'd0, err}, 32'd1);

    // reset while waiting in RESP
    cyc();
    drv(1, 4'h0, 32'h500, 32'h0);
    cyc();
    slv(1, 0, 32'h0);
    cyc();
    slv(0, 0, 32'h0);
    rst = 1;
    @(negedge clk);
    chk("rr_stall_in_rst", {31'd0, stall}, 32'd0);
    cyc();
    rst = 0;
    drv(0, 4'h0, 32'h0, 32'h0);
    slv(0, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rr_req", {31'd0, breq}, 32'd0);
    chk("rr_stall", {31'd0, stall}, 32'd0);
    chk("rr_err", {31'd0, err}, 32'd0);
    cyc();
    slv(0, 0, 32'h0);
    @(negedge clk);
    chk("rr_rdata", rdata, 32'h0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Responder/bridge for the data-memory interface the EX stage drives and the MEM stage reads (`data_sram_rdata`). It converts the CPU's single-cycle SRAM-style request into a split-transaction bus request with `addr_ok`/`data_ok` handshakes.
- It raises `stallreq` to the pipeline controller until the transaction completes.
- It presents registered read data that holds stable for MEM.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles spent waiting in REQ or RESP before forced completion with error.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- data_sram_en  in  1  CPU request valid (from EX)
- data_sram_wen  in  4  byte write enables; 0000 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  store data
- data_sram_rdata  out  32  registered load data to MEM
- stallreq  out  1  stall request to pipeline control
- bus_req  out  1  bus request valid
- bus_wr  out  1  1 = write
- bus_wstrb  out  4  byte strobes
- bus_addr  out  32  address
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  request accepted this cycle
- bus_data_ok  in  1  response/write-ack this cycle
- bus_rdata  in  32  read data, valid with bus_data_ok
- err  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - state = IDLE; bus_req = 0; bus_wr = 0; bus_wstrb = 0; bus_addr = 0; bus_wdata = 0.
  - data_sram_rdata = 0; err = 0; counter = 0.
  - stallreq forced 0 while rst.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - If `data_sram_en` is high, latch addr, wdata and wen into the bus_* registers, and set bus_wr = |wen and bus_req = 1.
  - Go to REQ.
- REQ (bus_req = 1, outputs held stable):
  - On `addr_ok`, drop bus_req.
  - If `data_ok` is also high in the same cycle, go to DONE; otherwise go to RESP.
- RESP (bus_req = 0): on `data_ok`, go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE. `data_sram_en` is ignored in DONE, because that request is the one just completed.
- Read data capture: on `data_ok` of a read, `data_sram_rdata <= bus_rdata`. On a write ack, `data_sram_rdata` is unchanged. The value holds until the next read completion.
- stallreq (combinational) = (IDLE & data_sram_en) | REQ | RESP. It is 0 in DONE, so the pipeline advances at the end of DONE and MEM sees valid rdata in the following cycle.
- Latency with a zero-wait slave (addr_ok and data_ok both high in the REQ cycle): request cycle → REQ → DONE, i.e. 2 stall cycles.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYC, set err = 1 (sticky until rst), drop bus_req, and go to DONE.
  - A read completes with data_sram_rdata = ERR_DATA.
- Stray `data_ok` in IDLE or DONE is ignored. Stray `addr_ok` outside REQ is ignored.
- Reset mid-transaction: return to IDLE immediately and drop bus_req. A late `data_ok` for the abandoned request is ignored.
- No second request is issued while REQ, RESP or DONE is active.

Test Plan:
- Read, 0-wait: en = 1, wen = 0, addr = 0x100; slave asserts addr_ok and data_ok together with rdata = 0x12345678.
  → stallreq high for 2 cycles, 0 in DONE; data_sram_rdata = 0x12345678 from the next cycle onward.
- Read, 3-cycle data latency: addr_ok after 1 cycle, data_ok after 3 more.
  → bus_req high only until addr_ok; stallreq high through RESP; rdata updated exactly on data_ok.
- Write: en = 1, wen = 0011, addr = 0x204, wdata = 0xAABBCCDD.
  → bus_wr = 1, bus_wstrb = 0011, bus_addr = 0x204, bus_wdata = 0xAABBCCDD; data_sram_rdata unchanged after ack.
- Back-to-back: read then store on consecutive instructions (en held high).
  → exactly one bus transaction per instruction; DONE produces no duplicate request.
- Timeout: TIMEOUT_CYC = 8, slave never asserts data_ok on a read.
  → after 8 cycles err = 1, data_sram_rdata = 0xDEADBEEF, stallreq drops, state returns to IDLE.
- Reset in RESP, then a late data_ok with rdata = 0xFFFFFFFF.
  → state is IDLE, data_sram_rdata = 0, stallreq = 0, bus_req = 0.
